if_fetch_q: RTL and testbench

IF_FETCH_Q -- requirements
Module: if_fetch_q

---
 rtl/if_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/if_fetch_q.sv | 141 ++++++++++++++
 tb/tb_if_fetch_q.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Purpose : shared types and defaults for the instruction-fetch queue.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM encoding, default RESET_PC/WRAP_PC values, and the
// queue-entry layout {inst, pc}. The entry is stored as one packed word with
// the instruction in the upper half and its PC in the lower half.
package if_pkg;

    localparam int unsigned IF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_WRAP_PC  = 32'h0000_0088;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Entry layout at the default datapath width; the queue keeps the same
    // bit order ({inst, pc}) for any XLEN.
    typedef struct packed {
        logic [IF_XLEN-1:0] inst;
        logic [IF_XLEN-1:0] pc;
    } q_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose : small synchronous FIFO holding fetched {inst, pc} entries.
// Latency : entry pushed at an edge is visible at the head after that edge.
// Backpressure: push is dropped only when full without a same-cycle pop;
//               the producer is expected to reserve space before issuing.
//
// Ports: CPUCLK/reset (sync, active low), flush (sync clear, wins over
// push/pop), push_vld/push_dat, pop_vld, head_dat (head entry), count.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             CPUCLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A full queue may still accept a push when the head leaves the same cycle.
    assign rd_en = pop_vld && (count != '0);
    assign wr_en = push_vld && ((count != CW'(DEPTH)) || rd_en);

    always_ff @(posedge CPUCLK) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage needs no reset: the head is only consumed while count != 0.
    always_ff @(posedge CPUCLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_q.sv
// Purpose : instruction fetch with PC generation, redirect flush and a
//           small decoupling queue toward decode.
// Latency : request to out_valid is 2 cycles; 1 instruction/cycle sustained.
// Backpressure: out_ready low holds the head; fetch stops issuing once
//               queued + in-flight entries would reach FIFO_DEPTH.
//
// Ports: CPUCLK, reset (sync, active low); redirect_valid/redirect_addr
// (taken-branch target); out_ready (decode accept); imem_en/imem_addr/
// imem_rdata (external ROM, 1-cycle read); out_valid/out_inst/out_pc/
// out_pc_add_4 (queue head).
module if_fetch_q
    import if_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_AW    = 7,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] WRAP_PC    = XLEN'(DEF_WRAP_PC)
) (
    input  logic               CPUCLK,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_addr,
    input  logic               out_ready,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_inst,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pc_add_4
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_nxt;
    logic              inflight;
    logic              req_epoch;
    logic [XLEN-1:0]   req_pc;
    logic              epoch;
    logic              issue;
    logic              pop;
    logic              push;
    logic [CW:0]       occ_sum;
    logic [CW-1:0]     q_count;
    logic [2*XLEN-1:0] q_head;
    logic [1:0]        unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_addr[1:0];

    assign out_valid = (q_count != '0);
    assign pop       = out_valid && out_ready;

    // Reserve a queue slot for every outstanding request so a response can
    // always be written; a same-cycle pop frees one slot early.
    assign occ_sum = {1'b0, q_count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign issue   = reset && !redirect_valid && (occ_sum < (CW + 1)'(FIFO_DEPTH));

    // A response is kept only if it belongs to the current epoch and is not
    // cancelled by a redirect in its own cycle.
    assign push = inflight && (req_epoch == epoch) && !redirect_valid
                  && (state != ST_FLUSH);

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_nxt = {redirect_addr[XLEN-1:2], 2'b00};
        end else if (!issue) begin
            fetch_pc_nxt = fetch_pc;
        end else if (fetch_pc == WRAP_PC) begin
            fetch_pc_nxt = RESET_PC;
        end else begin
            fetch_pc_nxt = fetch_pc + XLEN'(4);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = redirect_valid ? ST_FLUSH : ST_RUN;
            ST_RUN:   state_nxt = redirect_valid ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_nxt = redirect_valid ? ST_FLUSH : ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CPUCLK) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CPUCLK) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            inflight  <= 1'b0;
            req_epoch <= 1'b0;
            req_pc    <= '0;
            epoch     <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            inflight <= issue;
            if (issue) begin
                req_pc    <= fetch_pc;
                req_epoch <= epoch;
            end
            if (redirect_valid) begin
                epoch <= ~epoch;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN),
        .CW    (CW)
    ) u_fifo (
        .CPUCLK   (CPUCLK),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat ({imem_rdata, req_pc}),
        .pop_vld  (pop),
        .head_dat (q_head),
        .count    (q_count)
    );

    assign imem_en   = issue;
    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    // Head fields read as zero while empty, giving the reset-state outputs.
    assign out_inst     = out_valid ? q_head[2*XLEN-1:XLEN] : '0;
    assign out_pc       = out_valid ? q_head[XLEN-1:0] : '0;
    assign out_pc_add_4 = out_pc + XLEN'(4);

endmodule

// File: tb/tb_if_fetch_q.sv
module tb_if_fetch_q;

    logic        CPUCLK = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        out_ready;
    logic [31:0] imem_rdata;
    logic        imem_en;
    logic [6:0]  imem_addr;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_add_4;

    int tests = 0;
    int fails = 0;

    if_fetch_q dut (
        .CPUCLK         (CPUCLK),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_ready      (out_ready),
        .imem_rdata     (imem_rdata),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc_add_4   (out_pc_add_4)
    );

    always #5 CPUCLK = ~CPUCLK;

    // ROM word k holds k; undriven cycles return noise so stray writes show up.
    always @(posedge CPUCLK) begin
        if (imem_en) imem_rdata <= {25'd0, imem_addr};
        else         imem_rdata <= $urandom;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_of(input logic [31:0] pc);
        return (pc >> 2) & 32'h7F;
    endfunction

    function automatic logic [31:0] step_pc(input logic [31:0] pc);
        return (pc == 32'h88) ? 32'h0 : pc + 32'd4;
    endfunction

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] raddr;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [31:0] exp_ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] raddr,
                                input logic exp_vld, input logic [31:0] exp_pc,
                                input logic exp_en, input logic [31:0] exp_ipc);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.raddr = raddr;
        v.exp_vld = exp_vld; v.exp_pc = exp_pc; v.exp_en = exp_en; v.exp_ipc = exp_ipc;
        return v;
    endfunction

    vec_t vec [25];

    task automatic redirect_chk(input logic [31:0] addr);
        logic [31:0] tgt;
        tgt = addr & ~32'h3;
        @(negedge CPUCLK);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = addr;
        #1 chk("redir_imem_en", imem_en, 0);
        @(negedge CPUCLK);
        redirect_valid = 1'b0;
        chk("redir_vld_drop", out_valid, 0);
        @(negedge CPUCLK);
        @(negedge CPUCLK);
        chk("redir_vld", out_valid, 1);
        chk("redir_pc", out_pc, tgt);
        chk("redir_inst", out_inst, rom_of(tgt));
    endtask

    initial begin
        logic [31:0] wrap_seq [7];
        logic [31:0] exp_pc, prev_pc, a;
        logic        r, rdy;
        bit          synced, prev_redir, prev_stall;

        // cycle-by-cycle vectors, cycle 0 = first cycle with reset released
        vec[0]  = mk(1, 0, 0,     0, 0,     1, 32'h00);
        vec[1]  = mk(1, 0, 0,     0, 0,     1, 32'h04);
        vec[2]  = mk(1, 0, 0,     1, 32'h00, 1, 32'h08);
        vec[3]  = mk(1, 0, 0,     1, 32'h04, 1, 32'h0C);
        vec[4]  = mk(1, 0, 0,     1, 32'h08, 1, 32'h10);
        vec[5]  = mk(1, 0, 0,     1, 32'h0C, 1, 32'h14);
        vec[6]  = mk(0, 0, 0,     1, 32'h10, 0, 0);
        vec[7]  = mk(0, 0, 0,     1, 32'h10, 0, 0);
        vec[8]  = mk(0, 0, 0,     1, 32'h10, 0, 0);
        vec[9]  = mk(0, 0, 0,     1, 32'h10, 0, 0);
        vec[10] = mk(0, 0, 0,     1, 32'h10, 0, 0);
        vec[11] = mk(1, 0, 0,     1, 32'h10, 1, 32'h18);
        vec[12] = mk(1, 0, 0,     1, 32'h14, 1, 32'h1C);
        vec[13] = mk(1, 0, 0,     1, 32'h18, 1, 32'h20);
        vec[14] = mk(1, 1, 32'h43, 1, 32'h1C, 0, 0);
        vec[15] = mk(1, 0, 0,     0, 0,     1, 32'h40);
        vec[16] = mk(1, 0, 0,     0, 0,     1, 32'h44);
        vec[17] = mk(1, 0, 0,     1, 32'h40, 1, 32'h48);
        vec[18] = mk(1, 1, 32'h20, 1, 32'h44, 0, 0);
        vec[19] = mk(1, 1, 32'h60, 0, 0,     0, 0);
        vec[20] = mk(1, 0, 0,     0, 0,     1, 32'h60);
        vec[21] = mk(1, 0, 0,     0, 0,     1, 32'h64);
        vec[22] = mk(1, 0, 0,     1, 32'h60, 1, 32'h68);
        vec[23] = mk(1, 0, 0,     1, 32'h64, 1, 32'h6C);
        vec[24] = mk(1, 0, 0,     1, 32'h68, 1, 32'h70);

        reset = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b0;
        repeat (3) @(posedge CPUCLK);
        @(negedge CPUCLK);
        chk("rst_imem_en", imem_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_pc_add_4", out_pc_add_4, 32'h4);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge CPUCLK);
            out_ready = vec[i].rdy; redirect_valid = vec[i].redir; redirect_addr = vec[i].raddr;
            #1;
            chk($sformatf("vec%0d_vld", i), out_valid, vec[i].exp_vld);
            chk($sformatf("vec%0d_en", i), imem_en, vec[i].exp_en);
            if (vec[i].exp_en) chk($sformatf("vec%0d_iaddr", i), imem_addr, rom_of(vec[i].exp_ipc));
            if (vec[i].exp_vld) begin
                chk($sformatf("vec%0d_pc", i), out_pc, vec[i].exp_pc);
                chk($sformatf("vec%0d_inst", i), out_inst, rom_of(vec[i].exp_pc));
                chk($sformatf("vec%0d_pc4", i), out_pc_add_4, vec[i].exp_pc + 32'd4);
            end
        end
        redirect_valid = 1'b0;

        redirect_chk(32'h40);

        // free run across the wrap point
        wrap_seq[0] = 32'h78; wrap_seq[1] = 32'h7C; wrap_seq[2] = 32'h80; wrap_seq[3] = 32'h84;
        wrap_seq[4] = 32'h88; wrap_seq[5] = 32'h00; wrap_seq[6] = 32'h04;
        redirect_chk(wrap_seq[0]);
        for (int k = 1; k < 7; k++) begin
            @(negedge CPUCLK);
            chk($sformatf("wrap%0d_vld", k), out_valid, 1);
            chk($sformatf("wrap%0d_pc", k), out_pc, wrap_seq[k]);
            chk($sformatf("wrap%0d_inst", k), out_inst, rom_of(wrap_seq[k]));
        end

        // one-cycle reset in the middle of a stream
        @(negedge CPUCLK);
        reset = 1'b0;
        #1 chk("mrst_en_low", imem_en, 0);
        @(negedge CPUCLK);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_inst", out_inst, 0);
        chk("mrst_pc", out_pc, 0);
        chk("mrst_pc4", out_pc_add_4, 32'h4);
        reset = 1'b1;
        #1 chk("mrst_en", imem_en, 1);
        chk("mrst_iaddr", imem_addr, 0);
        @(negedge CPUCLK);
        chk("mrst_vld_gap", out_valid, 0);
        @(negedge CPUCLK);
        chk("mrst_refetch_vld", out_valid, 1);
        chk("mrst_refetch_pc", out_pc, 32'h0);
        @(negedge CPUCLK);
        chk("mrst_refetch_pc2", out_pc, 32'h4);

        // random traffic against a stream-level model
        synced = 0; prev_redir = 0; prev_stall = 0; exp_pc = 0; prev_pc = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge CPUCLK);
            if (synced) begin
                if (prev_redir) begin
                    chk("rnd_flush_vld", out_valid, 0);
                end else begin
                    if (prev_stall) begin
                        chk("rnd_stall_vld", out_valid, 1);
                        chk("rnd_stall_pc", out_pc, prev_pc);
                    end
                    if (out_valid) begin
                        chk("rnd_pc", out_pc, exp_pc);
                        chk("rnd_inst", out_inst, rom_of(exp_pc));
                        chk("rnd_pc4", out_pc_add_4, exp_pc + 32'd4);
                    end
                end
                if (i >= 1496) chk("rnd_drain_vld", out_valid, 1);
            end
            a = $urandom_range(0, 255);
            if (i == 0) begin
                r = 1'b1; rdy = 1'b1;
            end else if (i >= 1490) begin
                r = 1'b0; rdy = 1'b1;
            end else begin
                rdy = ($urandom % 4) != 0;
                r   = ($urandom % 12) == 0;
            end
            out_ready = rdy; redirect_valid = r; redirect_addr = a;
            if (r) exp_pc = a & ~32'h3;
            else if (synced && out_valid && rdy) exp_pc = step_pc(exp_pc);
            prev_pc    = out_pc;
            prev_stall = out_valid && !rdy && !r;
            prev_redir = r;
            synced     = 1;
        end

        @(negedge CPUCLK);
        redirect_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
